uart_tx_fifo: RTL

//  Byte buffer and launcher placed directly upstream of uart_tx.

---
 rtl/uart_tx_fifo_pkg.sv | 14 +
 rtl/uart_sync_fifo.sv | 73 +++++++
 rtl/uart_tx_fifo.sv | 99 +++++++++
 3 files changed

// File: rtl/uart_tx_fifo_pkg.sv
// Shared types and constants for the UART transmit FIFO slice.
// Launch FSM encodings and the uart_tx bit-period default used alongside it.
package uart_tx_fifo_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_GAP  = 2'b10
  } tx_state_e;

  localparam int CLKS_PER_BIT = 87;
  localparam int BYTE_W       = 8;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO: register-array storage, wrapping pointers, count, registered full/empty.
// Read data is the combinational head; pops are ignored when empty, pushes when full.
module uart_sync_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = BYTE_W
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  input  logic                  i_Wr_En,
  input  logic [DATA_WIDTH-1:0] i_Wr_Data,
  input  logic                  i_Rd_En,
  output logic [DATA_WIDTH-1:0] o_Rd_Data,
  output logic                  o_Full,
  output logic                  o_Empty,
  output logic [ADDR_WIDTH:0]   o_Count
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] ONE_CNT   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] ONE_PTR = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q;
  logic [ADDR_WIDTH-1:0] rd_ptr_q;
  logic [ADDR_WIDTH:0]   count_q;
  logic [ADDR_WIDTH:0]   count_d;
  logic                  full_q;
  logic                  empty_q;
  logic                  push;
  logic                  pop;

  assign push = i_Wr_En && !full_q;
  assign pop  = i_Rd_En && !empty_q;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + ONE_CNT;
      2'b01:   count_d = count_q - ONE_CNT;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + ONE_PTR;
      if (pop)  rd_ptr_q <= rd_ptr_q + ONE_PTR;
      count_q <= count_d;
      // Flags track the post-edge count so they are valid from the same edge.
      full_q  <= (count_d == DEPTH_CNT);
      empty_q <= (count_d == '0);
    end
  end

  always_ff @(posedge i_Clock) begin
    if (push) mem_q[wr_ptr_q] <= i_Wr_Data;
  end

  assign o_Rd_Data = mem_q[rd_ptr_q];
  assign o_Full    = full_q;
  assign o_Empty   = empty_q;
  assign o_Count   = count_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte queue and launcher in front of uart_tx; one launch per frame with a one-cycle gap after done.
// Optional UART_TX_FIFO_STATS_EN adds o_Level and a saturating o_Drop_Count for refused writes.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = BYTE_W
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  input  logic                  i_Wr_DV,
  input  logic [DATA_WIDTH-1:0] i_Wr_Byte,
  output logic                  o_Full,
  output logic                  o_Empty,
  output logic                  o_Tx_DV,
  output logic [DATA_WIDTH-1:0] o_Tx_Byte,
  input  logic                  i_Tx_Active,
`ifdef UART_TX_FIFO_STATS_EN
  output logic [ADDR_WIDTH:0]   o_Level,
  output logic [7:0]            o_Drop_Count,
`endif
  input  logic                  i_Tx_Done
);

  tx_state_e             state_q;
  logic                  tx_dv_q;
  logic [DATA_WIDTH-1:0] tx_byte_q;
  logic [DATA_WIDTH-1:0] head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [ADDR_WIDTH:0]   level;
  logic                  launch;

  assign launch = (state_q == S_IDLE) && !fifo_empty && !i_Tx_Active;

  uart_sync_fifo #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fifo (
    .i_Clock   (i_Clock),
    .i_Reset   (i_Reset),
    .i_Wr_En   (i_Wr_DV),
    .i_Wr_Data (i_Wr_Byte),
    .i_Rd_En   (launch),
    .o_Rd_Data (head),
    .o_Full    (fifo_full),
    .o_Empty   (fifo_empty),
    .o_Count   (level)
  );

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q   <= S_IDLE;
      tx_dv_q   <= 1'b0;
      tx_byte_q <= '0;
    end else begin
      tx_dv_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (launch) begin
            tx_dv_q   <= 1'b1;
            tx_byte_q <= head;
            state_q   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (i_Tx_Done) state_q <= S_GAP;
        end
        // uart_tx needs one cycle in its idle state before it accepts another pulse.
        S_GAP:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_Full    = fifo_full;
  assign o_Empty   = fifo_empty;
  assign o_Tx_DV   = tx_dv_q;
  assign o_Tx_Byte = tx_byte_q;

`ifdef UART_TX_FIFO_STATS_EN
  logic [7:0] drop_cnt_q;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      drop_cnt_q <= 8'h00;
    end else if (i_Wr_DV && fifo_full && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_q <= drop_cnt_q + 8'h01;
    end
  end

  assign o_Level      = level;
  assign o_Drop_Count = drop_cnt_q;
`else
  logic unused_level;
  assign unused_level = ^level;
`endif

endmodule
